// File: rtl/count_compare_pkg.sv
// Shared definitions for count_compare: register map, CTRL/STATUS bit positions,
// compare state machine encoding and a byte-lane write merge helper.
package count_compare_pkg;

  localparam logic [1:0] ADDR_COMPARE = 2'd0;
  localparam logic [1:0] ADDR_PERIOD  = 2'd1;
  localparam logic [1:0] ADDR_CTRL    = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_PERIODIC  = 1;
  localparam int CTRL_IRQ_EN    = 2;
  localparam int CTRL_W         = 3;

  localparam int STATUS_PENDING = 0;
  localparam int STATUS_OVERRUN = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } cc_state_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/count_compare.sv
// Compare unit watching an upstream free-running counter, with a small register bus.
// Define COUNT_COMPARE_OVERRUN_EN to flag matches that arrive while pending is still set.
module count_compare
  import count_compare_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] count,
  input  logic            valid,
  input  logic [1:0]      addr,
  input  logic [3:0]      wstrb,
  input  logic [31:0]     wdata,
  output logic            ready,
  output logic [31:0]     rdata,
  output logic            match,
  output logic            irq,
  output cc_state_e       state_o
);

  logic [BITS-1:0]   compare_q, compare_d;
  logic [BITS-1:0]   period_q, period_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              pending_q, pending_d;
  logic              overrun_q;
  logic              ready_q, ready_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              match_q, match_d;
  logic              block_q, block_d;
  cc_state_e         state_q, state_d;

  logic        access, wr_en, cmp_wr, ctrl_wr, status_wr, arm_req, hit;
  logic [31:0] rd_word, wr_word;

  // Bus handshake: valid is held by the requester until ready; ready is a single-cycle
  // ack issued the cycle after an unacknowledged valid, so an ack is never followed by
  // another one. After reset, a request still in flight must drop valid before it is served.
  assign access    = valid & ~ready_q & ~block_q;
  assign wr_en     = access & (|wstrb);
  assign cmp_wr    = wr_en & (addr == ADDR_COMPARE);
  assign ctrl_wr   = wr_en & (addr == ADDR_CTRL);
  assign status_wr = wr_en & (addr == ADDR_STATUS) & wstrb[0];
  assign wr_word   = byte_merge(rd_word, wdata, wstrb);
  assign arm_req   = cmp_wr | (ctrl_wr & wr_word[CTRL_ENABLE]);

  always_comb begin
    rd_word = '0;
    case (addr)
      ADDR_COMPARE: rd_word = 32'(compare_q);
      ADDR_PERIOD:  rd_word = 32'(period_q);
      ADDR_CTRL:    rd_word[CTRL_W-1:0] = ctrl_q;
      default: begin
        rd_word[STATUS_PENDING] = pending_q;
        rd_word[STATUS_OVERRUN] = overrun_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ctrl_wr && wr_word[CTRL_ENABLE]) state_d = ST_ARMED;
      ST_ARMED: if (hit && !ctrl_q[CTRL_PERIODIC] && !arm_req) state_d = ST_FIRED;
      ST_FIRED: if (arm_req) state_d = ST_ARMED;
      default:  state_d = ST_IDLE;
    endcase
    if (ctrl_wr && !wr_word[CTRL_ENABLE]) state_d = ST_IDLE;
  end

  always_comb begin
    hit = (state_q == ST_ARMED) && (count == compare_q);
  end

  assign state_o = state_q;

  // A bus write to COMPARE overrides the periodic reload; a match beats a W1C of pending.
  always_comb begin
    compare_d = compare_q;
    period_d  = period_q;
    ctrl_d    = ctrl_q;
    pending_d = pending_q;
    ready_d   = access;
    rdata_d   = access ? rd_word : rdata_q;
    match_d   = hit;
    block_d   = block_q & valid;
    if (hit && ctrl_q[CTRL_PERIODIC]) compare_d = compare_q + period_q;
    if (wr_en) begin
      case (addr)
        ADDR_COMPARE: compare_d = wr_word[BITS-1:0];
        ADDR_PERIOD:  period_d  = wr_word[BITS-1:0];
        ADDR_CTRL:    ctrl_d    = wr_word[CTRL_W-1:0];
        default:      ;
      endcase
    end
    if (status_wr && wdata[STATUS_PENDING]) pending_d = 1'b0;
    if (hit) pending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      compare_q <= '0;
      period_q  <= '0;
      ctrl_q    <= '0;
      pending_q <= 1'b0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      match_q   <= 1'b0;
      block_q   <= 1'b1;
    end else begin
      compare_q <= compare_d;
      period_q  <= period_d;
      ctrl_q    <= ctrl_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      match_q   <= match_d;
      block_q   <= block_d;
    end
  end

`ifdef COUNT_COMPARE_OVERRUN_EN
  logic overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (status_wr && wdata[STATUS_OVERRUN]) overrun_d = 1'b0;
    if (hit && pending_q) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overrun_q <= 1'b0;
    else       overrun_q <= overrun_d;
  end
`else
  assign overrun_q = 1'b0;
`endif

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign match = match_q;
  assign irq   = pending_q & ctrl_q[CTRL_IRQ_EN];

endmodule
